// File: rtl/pulse_train_gen.sv
// pulse_train_gen: on a start request, emits N single-cycle pulses spaced P clocks apart,
// then raises a one-cycle done strobe. All outputs are registered.
//
// A train accepted at edge e0 pulses in the cycles after edges e0+P, e0+2P, ... e0+N*P.
// The block then spends one cycle in StDone and returns to StIdle with done high.
// Because of that, a new start can be accepted on the edge that closes the done cycle.
module pulse_train_gen #(
   parameter int unsigned PERIOD_W = 8,
   parameter int unsigned COUNT_W  = 4
) (
   input  logic                clock,
   input  logic                clear_n,
   input  logic                start,
   input  logic                stop,
   input  logic [PERIOD_W-1:0] period,
   input  logic [COUNT_W-1:0]  count,
   output logic                pulse,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  pulses_sent
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e              state;
   logic [PERIOD_W-1:0] period_lat;  // P captured with start; input changes during RUN are ignored
   logic [PERIOD_W-1:0] timer;       // cycles left until the next pulse, reloaded with P
   logic [COUNT_W-1:0]  remaining;   // pulses still to be emitted in this train

   // Train sequencer: state, timer, counters and all registered outputs.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state       <= StIdle;
         period_lat  <= '0;
         timer       <= '0;
         remaining   <= '0;
         pulse       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulses_sent <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               pulse <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  pulses_sent <= '0;
                  if ((period != '0) && (count != '0)) begin
                     period_lat <= period;
                     timer      <= period;
                     remaining  <= count;
                     busy       <= 1'b1;
                     state      <= StRun;
                  end else begin
                     // Degenerate request: no pulses, just the completion strobe.
                     state <= StDone;
                  end
               end
            end

            StRun: begin
               if (stop) begin
                  // Abort wins over a pulse due on this same edge; pulses_sent holds.
                  pulse <= 1'b0;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (timer == PERIOD_W'(1)) begin
                  pulse       <= 1'b1;
                  pulses_sent <= pulses_sent + 1'b1;
                  timer       <= period_lat;
                  remaining   <= remaining - 1'b1;
                  // busy stays high through the cycle carrying the last pulse.
                  if (remaining == COUNT_W'(1)) begin
                     state <= StDone;
                  end
               end else begin
                  pulse <= 1'b0;
                  timer <= timer - 1'b1;
               end
            end

            StDone: begin
               // done is high in the cycle after this edge, by which time the block is idle.
               pulse <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= StIdle;
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an arithmetic train model.
module tb_pulse_train_gen;

   localparam int PW = 8;
   localparam int CW = 4;

   logic          clock   = 1'b0;
   logic          clear_n = 1'b0;
   logic          start   = 1'b0;
   logic          stop    = 1'b0;
   logic [PW-1:0] period  = '0;
   logic [CW-1:0] count   = '0;
   logic          pulse;
   logic          busy;
   logic          done;
   logic [CW-1:0] pulses_sent;

   int tests  = 0;
   int fails  = 0;
   int edge_n = -1;

   pulse_train_gen #(
      .PERIOD_W(PW),
      .COUNT_W (CW)
   ) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .start      (start),
      .stop       (stop),
      .period     (period),
      .count      (count),
      .pulse      (pulse),
      .busy       (busy),
      .done       (done),
      .pulses_sent(pulses_sent)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // ---------------------------------------------------------------------------------------
   // Reference model: a train is described only by its start edge e0, P and N (plus an
   // optional stop edge). Outputs after edge t follow from k = t - e0 by plain arithmetic.
   // ---------------------------------------------------------------------------------------
   bit armed   = 1'b0;
   bit have    = 1'b0;
   bit degen   = 1'b0;
   bit stopped = 1'b0;
   int e0, tp, tn, es;
   int free_at = 0;   // earliest edge at which a start is accepted

   initial begin
      int k, ep, eb, ed, eps;
      forever begin
         @(posedge clock);
         edge_n++;
         if (!clear_n) begin
            armed   = 1'b1;
            have    = 1'b0;
            free_at = edge_n + 1;
         end else if (have && !degen && !stopped && stop &&
                      edge_n > e0 && edge_n <= e0 + tn * tp) begin
            stopped = 1'b1;
            es      = edge_n;
            free_at = edge_n + 1;
         end else if (start && edge_n >= free_at) begin
            have    = 1'b1;
            stopped = 1'b0;
            e0      = edge_n;
            tp      = int'(period);
            tn      = int'(count);
            degen   = (tp == 0) || (tn == 0);
            free_at = degen ? edge_n + 2 : edge_n + tn * tp + 2;
         end

         ep = 0; eb = 0; ed = 0; eps = 0;
         if (have) begin
            k = edge_n - e0;
            if (degen) begin
               ed = (k == 1);
            end else if (stopped) begin
               eps = (es - 1 - e0) / tp;
            end else begin
               eb  = (k <= tn * tp);
               ep  = (k > 0) && (k % tp == 0) && (k / tp <= tn);
               eps = (k / tp < tn) ? k / tp : tn;
               ed  = (k == tn * tp + 1);
            end
         end

         @(negedge clock);
         if (armed) begin
            chk("model pulse", pulse, ep);
            chk("model busy", busy, eb);
            chk("model done", done, ed);
            chk("model pulses_sent", pulses_sent, eps);
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stimulus with literal expectations for the directed scenarios.
   // ---------------------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input int p, input int n);
      period = PW'(p);
      count  = CW'(n);
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   initial begin
      // Reset held for three edges with a valid start pending.
      clear_n = 1'b0;
      start   = 1'b1;
      period  = 8'd5;
      count   = 4'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset pulse", pulse, 0);
         chk("reset busy", busy, 0);
         chk("reset done", done, 0);
         chk("reset pulses_sent", pulses_sent, 0);
      end
      start   = 1'b0;
      clear_n = 1'b1;
      tick();
      chk("post-reset busy", busy, 0);

      // Basic train P=3 N=2.
      launch(3, 2);
      chk("basic busy e0", busy, 1);
      chk("basic pulse e0", pulse, 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("basic pulse", pulse, int'(k == 3 || k == 6));
         chk("basic busy", busy, int'(k <= 6));
         chk("basic done", done, int'(k == 7));
      end
      chk("basic pulses_sent", pulses_sent, 2);
      repeat (2) tick();

      // P=1, N=4 with start held: second train accepted at edge 6.
      period = 8'd1;
      count  = 4'd4;
      start  = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("b2b pulse", pulse, int'((k >= 1 && k <= 4) || (k >= 7 && k <= 10)));
         chk("b2b done", done, int'(k == 5));
         chk("b2b busy", busy, int'(k <= 4 || k >= 6));
      end
      start = 1'b0;
      repeat (3) tick();

      // Abort with a pulse due on the stop edge.
      launch(4, 3);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("abort pulse", pulse, int'(k == 4));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort pulse at stop", pulse, 0);
      chk("abort pulses_sent", pulses_sent, 1);
      tick();
      chk("abort no done", done, 0);
      tick();

      // Degenerate requests: N=0, then P=0.
      for (int d = 0; d < 2; d++) begin
         if (d == 0) launch(7, 0);
         else        launch(0, 5);
         chk("degen busy", busy, 0);
         chk("degen early done", done, 0);
         tick();
         chk("degen done", done, 1);
         chk("degen pulses_sent", pulses_sent, 0);
         chk("degen pulse", pulse, 0);
         tick();
         chk("degen done clears", done, 0);
      end

      // Reset mid-train; input changes after start must not matter.
      launch(2, 5);
      tick();
      period = 8'd9;
      count  = 4'd1;
      tick();
      chk("midreset pulse e2", pulse, 1);
      tick();
      chk("midreset pulse e3", pulse, 0);
      tick();
      chk("midreset pulse e4", pulse, 1);
      chk("midreset pulses_sent e4", pulses_sent, 2);
      clear_n = 1'b0;
      tick();
      clear_n = 1'b1;
      chk("midreset pulse", pulse, 0);
      chk("midreset busy", busy, 0);
      chk("midreset pulses_sent", pulses_sent, 0);
      tick();
      chk("midreset no done", done, 0);

      // Maximum period reload.
      launch(255, 2);
      for (int k = 1; k <= 512; k++) begin
         tick();
         if (k == 255 || k == 510) chk("maxp pulse", pulse, 1);
      end

      // Randomized traffic, checked by the model only.
      for (int i = 0; i < 4000; i++) begin
         clear_n = ($urandom_range(149) != 0);
         start   = ($urandom_range(2) == 0);
         stop    = ($urandom_range(15) == 0);
         period  = ($urandom_range(15) == 0) ? PW'($urandom_range(255)) : PW'($urandom_range(5));
         count   = ($urandom_range(15) == 0) ? CW'(15) : CW'($urandom_range(5));
         tick();
      end

      clear_n = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator for the time-entry path. On a start request it emits a fixed number of single-cycle pulses spaced a programmable number of clock cycles apart, then signals completion. It is the source end of the interval-timing chain: the downstream edge/interval counters consume its pulses, and this block produces them on a known cycle grid.

## Interface
- PERIOD_W, 8: width of the period input; spacing ranges from 1 to 2^PERIOD_W-1 cycles.
- COUNT_W, 4: width of the count input and of pulses_sent.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- clear_n  in  1  synchronous, active-low reset, sampled on posedge clock.
- start  in  1  request; accepted only in IDLE.
- stop  in  1  abort; effective only in RUN.
- period  in  PERIOD_W  cycles between pulses (P); sampled with start.
- count  in  COUNT_W  number of pulses (N); sampled with start.
- pulse  out  1  one-cycle output pulse.
- busy  out  1  high while a train is in progress.
- done  out  1  one-cycle completion strobe.
- pulses_sent  out  COUNT_W  pulses emitted in the current or last train.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset: clear_n low at a posedge forces IDLE from any state, including mid-train. After that edge pulse=0, busy=0, done=0, pulses_sent=0, and the internal timer and remaining-pulse counter are 0.
- IDLE:
  - start=1 with P≠0 and N≠0: latch P and N, clear pulses_sent, load timer with P, go to RUN.
  - start=1 with P=0 or N=0: go to DONE directly. No pulse; busy stays 0; pulses_sent is cleared to 0.
  - start=0: stay in IDLE.
- RUN:
  - Each cycle the timer decrements.
  - When the timer expires, pulse=1 for that one cycle, pulses_sent increments, and the timer reloads with P.
  - After the Nth pulse, go to DONE.
  - The latched P and N are unaffected by later changes on the period and count inputs.
  - start is ignored in RUN.
- stop=1 at an edge in RUN:
  - Next state is IDLE; pulse=0, busy=0, no done strobe.
  - pulses_sent holds its value.
  - stop takes priority over a pulse due on the same edge; that pulse is not emitted or counted.
- DONE: done=1 for exactly one cycle, then IDLE. start and stop are ignored in DONE.
- Widths:
  - The timer is PERIOD_W bits and pulses_sent is COUNT_W bits.
  - pulses_sent never exceeds N, so it never wraps.
  - Reload with P=2^PERIOD_W-1 is legal.

## Timing
- Start accepted at edge e0. In the cycle after e0: busy=1, pulse=0.
- Pulse i (i=1..N) is high in the cycle after edge e0+i·P, and pulses_sent=i in that same cycle.
- The cycle after e0+N·P has pulse=1, busy=1, pulses_sent=N.
- The cycle after e0+N·P+1 has done=1, busy=0, pulse=0.
- The cycle after e0+N·P+2 is IDLE. The earliest new start is accepted at edge e0+N·P+2.
- P=1: pulse is high for N consecutive cycles, in the cycles after edges e0+1 through e0+N.
- Degenerate start (P=0 or N=0) at e0: done=1 in the cycle after e0+1, busy never asserted.
- Stop accepted at edge es: the cycle after es has busy=0, pulse=0, and the block is IDLE. A new start can be accepted at es+1.
- Reset dominates start, stop and every state transition on the same edge.

## Test plan
- Reset: hold clear_n=0 for 3 edges with start=1, P=5, N=3. Required: pulse, busy, done and pulses_sent all 0; no train begins.
- Basic train: P=3, N=2, start at edge 0. Required: pulse after edges 3 and 6 only; busy after edges 1–6; done only after edge 7; pulses_sent=2.
- Back-to-back and P=1: P=1, N=4, start at edge 0 and start held high. Required: pulse after edges 1–4; done after edge 5; second train accepted at edge 6 with its pulses after edges 7–10.
- Abort: P=4, N=3, start at edge 0, stop=1 at edge 8 (second pulse due then). Required: exactly one pulse (after edge 4); pulses_sent=1; busy=0 after edge 8; no done.
- Degenerate: start with N=0, P=7, then with P=0, N=5. Required for each: no pulse, busy stays 0, done high one cycle after edge e0+1, pulses_sent=0.
- Reset mid-train and input changes: P=2, N=5, start at edge 0. Change period/count inputs at edge 1 to P=9, N=1, then drive clear_n=0 at edge 5. Required: pulses after edges 2 and 4 (latched P=2); all outputs 0 after edge 5; no done.
